// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration register bank and its write arbiter:
// register addresses, bank size, FSM states and requester source encoding.
package pwm_cfg_pkg;

  localparam int NUM_REGS = 5;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/pwm_cfg_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; req[0]/grant[0] is port A, req[1]/grant[1] is port B.
// Purely combinational: the last-grant pointer is owned and updated by the parent.
module rr_arb2
  import pwm_cfg_pkg::*;
(
  input  logic [1:0] req,
  input  src_e       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // On contention the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == SRC_B) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// PWM configuration register bank with a two-port round-robin write arbiter.
// A granted write is held for one COMMIT cycle, then written and reported downstream.
module pwm_cfg_arbiter #(
  parameter int NUM_REGS = pwm_cfg_pkg::NUM_REGS,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_src,
  output logic              addr_err
);
  import pwm_cfg_pkg::*;

  localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(NUM_REGS);

  state_e            state;
  state_e            next_state;
  src_e              last_grant;
  src_e              hold_src;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [1:0]        grant;
  logic              arb_enable;
  logic              handshake;
  logic              addr_ok;

  // Readys are forced low while in reset so no handshake can be taken then.
  assign arb_enable = (state == IDLE) && rst_n;
  assign addr_ok    = (hold_addr < REG_LIMIT);

  rr_arb2 u_arb (
    .req        ({b_valid, a_valid}),
    .last_grant (last_grant),
    .enable     (arb_enable),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    a_ready   = grant[0];
    b_ready   = grant[1];
    handshake = (a_valid && a_ready) || (b_valid && b_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_addr <= '0;
      hold_data <= '0;
      hold_src  <= SRC_A;
    end else if (handshake) begin
      hold_addr <= grant[1] ? b_addr : a_addr;
      hold_data <= grant[1] ? b_data : a_data;
      hold_src  <= grant[1] ? SRC_B : SRC_A;
    end
  end

  // Commit stage: an out-of-range address still moves the pointer but only flags addr_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_strobe       <= 1'b0;
      wr_addr         <= '0;
      wr_src          <= 1'b0;
      addr_err        <= 1'b0;
      last_grant      <= SRC_B;
    end else begin
      wr_strobe <= 1'b0;
      addr_err  <= 1'b0;
      if (state == COMMIT) begin
        last_grant <= hold_src;
        if (addr_ok) begin
          wr_strobe <= 1'b1;
          wr_addr   <= hold_addr;
          wr_src    <= hold_src;
          case (hold_addr)
            ADDR_EN_OUT_LO: en_reg_out_7_0  <= hold_data;
            ADDR_EN_OUT_HI: en_reg_out_15_8 <= hold_data;
            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= hold_data;
            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= hold_data;
            ADDR_DUTY:      pwm_duty_cycle  <= hold_data;
            default:        ;
          endcase
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Self-checking bench for pwm_cfg_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the register bank and the arbitration rule.
module tb_pwm_cfg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe, wr_src, addr_err;
  logic [6:0] wr_addr;

  logic [7:0] dut_regs [5];
  logic [7:0] exp_regs [5];
  logic       ptr_b;
  int         n_checks = 0;
  int         n_fails  = 0;

  always #5 clk = ~clk;

  pwm_cfg_arbiter dut (
    .clk (clk), .rst_n (rst_n),
    .a_valid (a_valid), .a_ready (a_ready), .a_addr (a_addr), .a_data (a_data),
    .b_valid (b_valid), .b_ready (b_ready), .b_addr (b_addr), .b_data (b_data),
    .en_reg_out_7_0 (en_reg_out_7_0), .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0), .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_strobe (wr_strobe), .wr_addr (wr_addr), .wr_src (wr_src), .addr_err (addr_err)
  );

  always_comb begin
    dut_regs[0] = en_reg_out_7_0;
    dut_regs[1] = en_reg_out_15_8;
    dut_regs[2] = en_reg_pwm_7_0;
    dut_regs[3] = en_reg_pwm_15_8;
    dut_regs[4] = pwm_duty_cycle;
  end

  // A waiting requester must keep its request stable until it is accepted.
  assert property (@(posedge clk) disable iff (!rst_n)
    (a_valid && !a_ready) |=> (a_valid && $stable(a_addr) && $stable(a_data)));
  assert property (@(posedge clk) disable iff (!rst_n)
    (b_valid && !b_ready) |=> (b_valid && $stable(b_addr) && $stable(b_data)));

  task automatic test_reset();
    a_valid = 1'b1; a_addr = 7'h03; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 7'h03; b_data = 8'h22;
    rst_n = 1'b0;
    foreach (exp_regs[i]) exp_regs[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fails++;
      $display("[TB] FAIL reset_readys: got a=%b b=%b expected a=0 b=0", a_ready, b_ready); end
    n_checks++; if (wr_strobe !== 1'b0 || addr_err !== 1'b0) begin n_fails++;
      $display("[TB] FAIL reset_strobes: got strobe=%b err=%b expected 0 0", wr_strobe, addr_err); end
    n_checks++; if (wr_addr !== 7'h00 || wr_src !== 1'b0) begin n_fails++;
      $display("[TB] FAIL reset_wr_info: got addr=%h src=%b expected 00 0", wr_addr, wr_src); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (dut_regs[i] !== 8'h00) begin n_fails++;
        $display("[TB] FAIL reset_reg%0d: got %h expected 00", i, dut_regs[i]); end
    end
    rst_n = 1'b1; #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fails++;
      $display("[TB] FAIL reset_first_grant: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    @(negedge clk); a_valid = 1'b0; #1;
    n_checks++; if (b_ready !== 1'b0 || wr_strobe !== 1'b0) begin n_fails++;
      $display("[TB] FAIL reset_commit_cycle: got b_ready=%b strobe=%b expected 0 0", b_ready, wr_strobe); end
    @(negedge clk); #1;
    exp_regs[3] = 8'h11;
    n_checks++; if (b_ready !== 1'b1 || wr_strobe !== 1'b1 || wr_src !== 1'b0 || wr_addr !== 7'h03) begin n_fails++;
      $display("[TB] FAIL reset_a_commit: got b_ready=%b strobe=%b src=%b addr=%h expected 1 1 0 03",
               b_ready, wr_strobe, wr_src, wr_addr); end
    n_checks++; if (en_reg_pwm_15_8 !== 8'h11) begin n_fails++;
      $display("[TB] FAIL reset_a_data: got %h expected 11", en_reg_pwm_15_8); end
    @(negedge clk); b_valid = 1'b0;
    @(negedge clk); #1;
    exp_regs[3] = 8'h22;
    n_checks++; if (wr_strobe !== 1'b1 || wr_src !== 1'b1 || en_reg_pwm_15_8 !== 8'h22) begin n_fails++;
      $display("[TB] FAIL reset_b_commit: got strobe=%b src=%b reg=%h expected 1 1 22",
               wr_strobe, wr_src, en_reg_pwm_15_8); end
    ptr_b = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk); a_valid = 1'b1; a_addr = 7'h02; a_data = 8'hA5; #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fails++;
      $display("[TB] FAIL single_ready: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    @(negedge clk); a_valid = 1'b0; #1;
    n_checks++; if (en_reg_pwm_7_0 !== 8'h00 || wr_strobe !== 1'b0) begin n_fails++;
      $display("[TB] FAIL single_early: got reg=%h strobe=%b expected 00 0", en_reg_pwm_7_0, wr_strobe); end
    @(negedge clk); #1;
    exp_regs[2] = 8'hA5; ptr_b = 1'b0;
    n_checks++; if (wr_strobe !== 1'b1 || wr_addr !== 7'h02 || wr_src !== 1'b0) begin n_fails++;
      $display("[TB] FAIL single_strobe: got strobe=%b addr=%h src=%b expected 1 02 0", wr_strobe, wr_addr, wr_src); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (dut_regs[i] !== exp_regs[i]) begin n_fails++;
        $display("[TB] FAIL single_reg%0d: got %h expected %h", i, dut_regs[i], exp_regs[i]); end
    end
    @(negedge clk); #1;
    n_checks++; if (wr_strobe !== 1'b0) begin n_fails++;
      $display("[TB] FAIL single_pulse_width: got strobe=%b expected 0", wr_strobe); end
  endtask

  task automatic test_lone_requester();
    int strobes = 0;
    int b_grants = 0;
    logic [7:0] next_data = 8'h01;
    @(negedge clk); b_valid = 1'b1; b_addr = 7'h00; b_data = next_data;
    for (int cyc = 0; cyc < 7; cyc++) begin
      #1;
      n_checks++; if (a_ready !== 1'b0) begin n_fails++;
        $display("[TB] FAIL lone_no_a_grant: cycle %0d got a_ready=%b expected 0", cyc, a_ready); end
      n_checks++; if (b_ready !== (b_valid && (cyc % 2 == 0))) begin n_fails++;
        $display("[TB] FAIL lone_b_ready: cycle %0d got %b expected %b", cyc, b_ready, b_valid && (cyc % 2 == 0)); end
      if (b_ready) b_grants++;
      if (wr_strobe) strobes++;
      @(negedge clk);
      if (cyc % 2 == 0) begin
        if (next_data == 8'h03) b_valid = 1'b0;
        else begin next_data = next_data + 8'h01; b_data = next_data; end
      end
    end
    #1;
    if (wr_strobe) strobes++;
    exp_regs[0] = 8'h03; ptr_b = 1'b1;
    n_checks++; if (en_reg_out_7_0 !== 8'h03) begin n_fails++;
      $display("[TB] FAIL lone_final: got %h expected 03", en_reg_out_7_0); end
    n_checks++; if (strobes != 3 || b_grants != 3) begin n_fails++;
      $display("[TB] FAIL lone_counts: got strobes=%0d grants=%0d expected 3 3", strobes, b_grants); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 7'h04; a_data = 8'h10;
    b_valid = 1'b1; b_addr = 7'h04; b_data = 8'h20; #1;
    n_checks++; if (a_ready !== ptr_b || b_ready !== !ptr_b) begin n_fails++;
      $display("[TB] FAIL contention_first: got a=%b b=%b expected a=%b b=%b", a_ready, b_ready, ptr_b, !ptr_b); end
    @(negedge clk); a_valid = 1'b0; #1;
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fails++;
      $display("[TB] FAIL contention_commit: got a=%b b=%b expected 0 0", a_ready, b_ready); end
    @(negedge clk); #1;
    n_checks++; if (b_ready !== 1'b1 || pwm_duty_cycle !== 8'h10 || wr_src !== 1'b0 || wr_strobe !== 1'b1) begin n_fails++;
      $display("[TB] FAIL contention_a: got b_ready=%b duty=%h src=%b strobe=%b expected 1 10 0 1",
               b_ready, pwm_duty_cycle, wr_src, wr_strobe); end
    @(negedge clk); b_valid = 1'b0;
    @(negedge clk); #1;
    exp_regs[4] = 8'h20; ptr_b = 1'b1;
    n_checks++; if (pwm_duty_cycle !== 8'h20 || wr_src !== 1'b1 || wr_strobe !== 1'b1) begin n_fails++;
      $display("[TB] FAIL contention_b: got duty=%h src=%b strobe=%b expected 20 1 1", pwm_duty_cycle, wr_src, wr_strobe); end
  endtask

  task automatic test_invalid_addr();
    @(negedge clk); a_valid = 1'b1; a_addr = 7'h05; a_data = 8'hFF; #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fails++;
      $display("[TB] FAIL invalid_ready: got %b expected 1", a_ready); end
    @(negedge clk); a_valid = 1'b0;
    @(negedge clk); #1;
    ptr_b = 1'b0;
    n_checks++; if (addr_err !== 1'b1 || wr_strobe !== 1'b0) begin n_fails++;
      $display("[TB] FAIL invalid_flags: got err=%b strobe=%b expected 1 0", addr_err, wr_strobe); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (dut_regs[i] !== exp_regs[i]) begin n_fails++;
        $display("[TB] FAIL invalid_reg%0d: got %h expected %h", i, dut_regs[i], exp_regs[i]); end
    end
    @(negedge clk); #1;
    n_checks++; if (addr_err !== 1'b0) begin n_fails++;
      $display("[TB] FAIL invalid_pulse_width: got err=%b expected 0", addr_err); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk); a_valid = 1'b1; a_addr = 7'h01; a_data = 8'h5A; #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fails++;
      $display("[TB] FAIL midrst_ready: got %b expected 1", a_ready); end
    @(negedge clk); a_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); #1;
    foreach (exp_regs[i]) exp_regs[i] = 8'h00;
    ptr_b = 1'b1;
    n_checks++; if (en_reg_out_15_8 !== 8'h00 || wr_strobe !== 1'b0 || wr_addr !== 7'h00) begin n_fails++;
      $display("[TB] FAIL midrst_discard: got reg=%h strobe=%b addr=%h expected 00 0 00", en_reg_out_15_8, wr_strobe, wr_addr); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (dut_regs[i] !== 8'h00) begin n_fails++;
        $display("[TB] FAIL midrst_reg%0d: got %h expected 00", i, dut_regs[i]); end
    end
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 7'h01; a_data = 8'h5A;
    b_valid = 1'b1; b_addr = 7'h00; b_data = 8'h77; #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fails++;
      $display("[TB] FAIL midrst_idle_grant: got a=%b b=%b expected 1 0", a_ready, b_ready); end
    @(negedge clk); a_valid = 1'b0;
    @(negedge clk); #1;
    exp_regs[1] = 8'h5A;
    n_checks++; if (en_reg_out_15_8 !== 8'h5A || b_ready !== 1'b1) begin n_fails++;
      $display("[TB] FAIL midrst_rewrite: got reg=%h b_ready=%b expected 5a 1", en_reg_out_15_8, b_ready); end
    @(negedge clk); b_valid = 1'b0;
    @(negedge clk); #1;
    exp_regs[0] = 8'h77;
    n_checks++; if (en_reg_out_7_0 !== 8'h77 || wr_src !== 1'b1) begin n_fails++;
      $display("[TB] FAIL midrst_b_write: got reg=%h src=%b expected 77 1", en_reg_out_7_0, wr_src); end
  endtask

  // Transaction-level model: a grant takes one busy cycle, then the write lands.
  task automatic test_random();
    bit   busy = 0;
    bit   ga, gb, a_done = 0, b_done = 0;
    int   h_addr = 0;
    logic [7:0] h_data = 8'h00;
    bit   h_src = 0;
    bit   e_strobe = 0, e_err = 0, e_src = 0;
    int   e_addr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (a_done) a_valid = 1'b0;
      if (b_done) b_valid = 1'b0;
      if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1'b1;
        a_addr  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
        a_data  = 8'($urandom);
      end
      if (!b_valid && $urandom_range(0, 2) != 0) begin
        b_valid = 1'b1;
        b_addr  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
        b_data  = 8'($urandom);
      end
      #1;
      ga = !busy && a_valid && (!b_valid || ptr_b);
      gb = !busy && b_valid && !ga;
      n_checks++; if (a_ready !== ga || b_ready !== gb) begin n_fails++;
        $display("[TB] FAIL rand_ready: cycle %0d got a=%b b=%b expected a=%b b=%b", cyc, a_ready, b_ready, ga, gb); end
      n_checks++; if (wr_strobe !== e_strobe || addr_err !== e_err) begin n_fails++;
        $display("[TB] FAIL rand_flags: cycle %0d got strobe=%b err=%b expected %b %b", cyc, wr_strobe, addr_err, e_strobe, e_err); end
      if (e_strobe) begin
        n_checks++; if (wr_addr !== 7'(e_addr) || wr_src !== e_src) begin n_fails++;
          $display("[TB] FAIL rand_wr_info: cycle %0d got addr=%h src=%b expected %h %b", cyc, wr_addr, wr_src, 7'(e_addr), e_src); end
      end
      for (int i = 0; i < 5; i++) begin
        n_checks++; if (dut_regs[i] !== exp_regs[i]) begin n_fails++;
          $display("[TB] FAIL rand_reg%0d: cycle %0d got %h expected %h", i, cyc, dut_regs[i], exp_regs[i]); end
      end
      @(posedge clk);
      e_strobe = 0; e_err = 0;
      a_done = ga; b_done = gb;
      if (busy) begin
        busy  = 0;
        ptr_b = h_src;
        if (h_addr < 5) begin
          exp_regs[h_addr] = h_data;
          e_strobe = 1; e_addr = h_addr; e_src = h_src;
        end else begin
          e_err = 1;
        end
      end else if (ga || gb) begin
        busy   = 1;
        h_addr = ga ? int'(a_addr) : int'(b_addr);
        h_data = ga ? a_data : b_data;
        h_src  = gb;
      end
    end
    @(negedge clk);
    if (a_done) a_valid = 1'b0;
    if (b_done) b_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    test_reset();
    test_single_write();
    test_lone_requester();
    test_contention();
    test_invalid_addr();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
